bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares the 1024x32 dual-port block RAM between NREQ independent requesters, e.g. instruction fetch, load/store unit and a debug/DMA loader.
- Grants up to two requests per cycle, one on BRAM port A and one on port B, using round-robin fairness.
- Prevents same-address write collisions between ports.
- Routes each registered BRAM read result back to the requester that issued it, one cycle after grant.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 10, BRAM word-address width.
- DATA_W, 32, BRAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  request granted this cycle; the request completes when valid&&ready.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed word addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data.
- rsp_valid  out  NREQ  completion strobe, one cycle after grant.
- rsp_rdata  out  NREQ*DATA_W  packed read data; valid only while the matching rsp_valid bit is high.
- bram_we_a  out  1  port A write enable.
- bram_addr_a  out  ADDR_W  port A address.
- bram_din_a  out  DATA_W  port A write data.
- bram_dout_a  in  DATA_W  port A registered read data.
- bram_we_b, bram_addr_b, bram_din_b, bram_dout_b: same as port A, for port B.

Behaviour:
- Grant logic is combinational from req_valid and the round-robin pointer rr_ptr (registered, width clog2(NREQ)).
- Scan order is rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
- First valid requester found → port A. Second valid requester found → port B.
- Collision rule: if both candidates have equal addresses and at least one is a write, port B is not granted. The second requester waits (req_ready=0). A read/read pair to the same address is granted on both ports.
- Ungranted port: we=0, addr=0, din=0.
- rr_ptr update on any grant: set to (index of last granted requester + 1) mod NREQ. With no grant, rr_ptr holds.
- Response pipeline, one stage:
  - Registers per port: vld_a/vld_b and id_a/id_b, capturing grant and requester index at the clock edge.
  - Next cycle: rsp_valid[id_a] = vld_a and rsp_valid[id_b] = vld_b.
  - rsp_rdata slice id_a = bram_dout_a; slice id_b = bram_dout_b. Other slices are 0.
  - Total latency: grant cycle N → rsp_valid in cycle N+1.
- Write responses: rsp_valid pulses as an acknowledge. rdata returns the old memory contents (read-before-write), and requesters must ignore it.
- No response backpressure; requesters must accept rsp_valid whenever it occurs.
- A requester may be granted again in the cycle its response returns (full throughput of 1 request/cycle per requester when the other ports are idle).
- A single requester is never granted on both ports in the same cycle.
- Reset, while rst is high:
  - rr_ptr=0, vld_a=vld_b=0, id_a=id_b=0.
  - req_ready=0, rsp_valid=0, bram_we_a=bram_we_b=0.
- Reset asserted mid-operation: in-flight responses are discarded immediately (rsp_valid drops asynchronously). BRAM contents are not restored; a write granted in the same edge as reset release does not occur because grants are masked while rst=1.
- NREQ=2: both requesters may be served every cycle absent collisions.

Decomposition:
- Shared package bram_arb_pkg holds:
  - constants BRAM_ADDR_W=10 and BRAM_DATA_W=32;
  - a function for round-robin index wrap;
  - the requester-ID width function clog2(NREQ).
- One sub-module: rr_pick2, a combinational picker returning the first two valid indices from a start pointer, plus found flags.
- The collision check, pipeline registers and response routing stay in the top.

Test Plan:
- Single read: requester 0 reads addr 0x005 (preloaded 0xDEADBEEF) → req_ready[0]=1 in cycle N; cycle N+1 rsp_valid=3'b001, slice 0 = 0xDEADBEEF.
- Dual grant: requesters 0 and 1 read 0x010 and 0x020 simultaneously → both ready in one cycle, both rsp_valid next cycle with correct data on correct slices.
- Collision: requester 0 writes 0x3FF=0x12345678 while requester 1 reads 0x3FF → only req 0 granted; req 1 granted next cycle and reads 0x12345678.
- Fairness: all 3 requesters hold valid reads for 6 cycles, rr_ptr=0 → grant pairs (0,1), (2,0), (1,2), ...; each requester receives exactly 4 grants.
- Write ack: write 0x0AA=0x55AA55AA → rsp_valid next cycle; a following read returns 0x55AA55AA.
- Async reset: assert rst between grant and response → rsp_valid stays 0 and req_ready=0 immediately; after release the first grant starts from requester 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared constants and helpers for the dual-port BRAM arbiter.
package bram_arb_pkg;
  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DATA_W = 32;

  // Wrap an index into [0, n). Callers never pass idx >= 2n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bram_port_arbiter_rr_pick2.sv
// Combinational round-robin picker: first two valid indices scanning from start_i.
module rr_pick2
  import bram_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  start_i,
  output logic [IDW-1:0]  first_o,
  output logic [IDW-1:0]  second_o,
  output logic            found1_o,
  output logic            found2_o
);
  logic [IDW-1:0] fst, snd;
  logic           f1, f2;
  int             idx;

  always_comb begin
    fst = '0;
    snd = '0;
    f1  = 1'b0;
    f2  = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_wrap(int'(start_i) + k, NREQ);
      if (valid_i[idx]) begin
        if (!f1) begin
          f1  = 1'b1;
          fst = IDW'(idx);
        end else if (!f2) begin
          f2  = 1'b1;
          snd = IDW'(idx);
        end
      end
    end
  end

  assign first_o  = fst;
  assign second_o = snd;
  assign found1_o = f1;
  assign found2_o = f2;
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing a dual-port BRAM between NREQ requesters,
// with same-address write-collision blocking and one-cycle response routing.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*DATA_W-1:0] rsp_rdata,
  output logic                   bram_we_a,
  output logic [ADDR_W-1:0]      bram_addr_a,
  output logic [DATA_W-1:0]      bram_din_a,
  input  logic [DATA_W-1:0]      bram_dout_a,
  output logic                   bram_we_b,
  output logic [ADDR_W-1:0]      bram_addr_b,
  output logic [DATA_W-1:0]      bram_din_b,
  input  logic [DATA_W-1:0]      bram_dout_b
);
  localparam int IDW = id_w(NREQ);

  logic [ADDR_W-1:0] addr_v  [NREQ];
  logic [DATA_W-1:0] wdata_v [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_v[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_v[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] idx_a, idx_b;
  logic           fnd_a, fnd_b;

  rr_pick2 #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i  (req_valid),
    .start_i  (rr_ptr_q),
    .first_o  (idx_a),
    .second_o (idx_b),
    .found1_o (fnd_a),
    .found2_o (fnd_b)
  );

  // Equal-address pair with any write: port B backs off; read/read is safe.
  logic collide, gnt_a, gnt_b;
  assign collide = (addr_v[idx_a] == addr_v[idx_b]) && (req_we[idx_a] || req_we[idx_b]);
  assign gnt_a   = fnd_a && !rst;
  assign gnt_b   = fnd_b && !collide && !rst;

  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[idx_a] = 1'b1;
    if (gnt_b) req_ready[idx_b] = 1'b1;
  end

  assign bram_we_a   = gnt_a && req_we[idx_a];
  assign bram_addr_a = gnt_a ? addr_v[idx_a]  : '0;
  assign bram_din_a  = gnt_a ? wdata_v[idx_a] : '0;
  assign bram_we_b   = gnt_b && req_we[idx_b];
  assign bram_addr_b = gnt_b ? addr_v[idx_b]  : '0;
  assign bram_din_b  = gnt_b ? wdata_v[idx_b] : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_b)      rr_ptr_d = IDW'(rr_wrap(int'(idx_b) + 1, NREQ));
    else if (gnt_a) rr_ptr_d = IDW'(rr_wrap(int'(idx_a) + 1, NREQ));
  end

  logic           vld_a_q, vld_b_q;
  logic [IDW-1:0] id_a_q, id_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      id_a_q   <= '0;
      id_b_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_a_q  <= gnt_a;
      vld_b_q  <= gnt_b;
      id_a_q   <= idx_a;
      id_b_q   <= idx_b;
    end
  end

  // A requester never holds both ports at once, so the two hits are exclusive.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (vld_a_q && id_a_q == IDW'(i)) begin
        rsp_valid[i]                 = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = bram_dout_a;
      end else if (vld_b_q && id_b_q == IDW'(i)) begin
        rsp_valid[i]                 = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = bram_dout_b;
      end
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter against a read-before-write dual-port BRAM model.
module tb_bram_port_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 10;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata, rsp_rdata;
  logic                 bram_we_a, bram_we_b;
  logic [AW-1:0]        bram_addr_a, bram_addr_b;
  logic [DW-1:0]        bram_din_a, bram_din_b, bram_dout_a, bram_dout_b;

  int n_tests = 0;
  int n_fail  = 0;
  int gcnt [NREQ];

  always #5 clk = ~clk;

  bram_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a), .bram_dout_a(bram_dout_a),
    .bram_we_b(bram_we_b), .bram_addr_b(bram_addr_b), .bram_din_b(bram_din_b), .bram_dout_b(bram_dout_b)
  );

  // BRAM model; preload values are (re)written while reset is held.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h005] <= 32'hDEADBEEF;
      mem[10'h010] <= 32'h01010101;
      mem[10'h020] <= 32'h02020202;
      mem[10'h030] <= 32'h03030303;
    end
    if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
    if (bram_we_b) mem[bram_addr_b] <= bram_din_b;
    bram_dout_a <= mem[bram_addr_a];
    bram_dout_b <= mem[bram_addr_b];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] fair_exp [3];
    fair_exp[0] = 3'b011; fair_exp[1] = 3'b101; fair_exp[2] = 3'b110;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv",  rsp_valid, 0);
    chk("rst_we",    {bram_we_a, bram_we_b}, 0);
    tick();
    rst = 1'b0;

    // single read
    set_req(0, 1, 0, 10'h005, 0);
    #1;
    chk("single_ready", req_ready, 3'b001);
    chk("single_addr_a", bram_addr_a, 10'h005);
    chk("single_idle_b", {bram_we_b, bram_addr_b, bram_din_b}, 0);
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("single_rspv", rsp_valid, 3'b001);
    chk("single_rdata", rsp_rdata, {32'h0, 32'h0, 32'hDEADBEEF});

    // dual grant (rr_ptr=1 now)
    set_req(0, 1, 0, 10'h010, 0);
    set_req(1, 1, 0, 10'h020, 0);
    #1;
    chk("dual_ready", req_ready, 3'b011);
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    chk("dual_rspv", rsp_valid, 3'b011);
    chk("dual_rdata", rsp_rdata, {32'h0, 32'h02020202, 32'h01010101});

    // collision: rr_ptr=0 so requester 0's write goes first
    do_reset();
    set_req(0, 1, 1, 10'h3FF, 32'h12345678);
    set_req(1, 1, 0, 10'h3FF, 0);
    #1;
    chk("coll_ready", req_ready, 3'b001);
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("coll_ack", rsp_valid, 3'b001);
    #1;
    chk("coll_ready2", req_ready, 3'b010);
    tick();
    set_req(1, 0, 0, 0, 0);
    chk("coll_rspv", rsp_valid, 3'b010);
    chk("coll_rdata", rsp_rdata, {32'h0, 32'h12345678, 32'h0});

    // fairness from rr_ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    set_req(0, 1, 0, 10'h010, 0);
    set_req(1, 1, 0, 10'h020, 0);
    set_req(2, 1, 0, 10'h030, 0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("fair_ready_c%0d", c), req_ready, fair_exp[c % 3]);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gcnt[i]++;
      tick();
      chk($sformatf("fair_rspv_c%0d", c), rsp_valid, fair_exp[c % 3]);
    end
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_cnt%0d", i), gcnt[i], 4);

    // write ack then back-to-back read by requester 2
    set_req(2, 1, 1, 10'h0AA, 32'h55AA55AA);
    #1;
    chk("wr_ready", req_ready, 3'b100);
    chk("wr_we_a", {bram_we_a, bram_addr_a, bram_din_a}, {1'b1, 10'h0AA, 32'h55AA55AA});
    tick();
    chk("wr_ack", rsp_valid, 3'b100);
    set_req(2, 1, 0, 10'h0AA, 0);
    #1;
    chk("rd_ready", req_ready, 3'b100);
    tick();
    set_req(2, 0, 0, 0, 0);
    chk("rd_rspv", rsp_valid, 3'b100);
    chk("rd_rdata", rsp_rdata, {32'h55AA55AA, 32'h0, 32'h0});

    // async reset mid-flight
    set_req(0, 1, 0, 10'h005, 0);
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 0, 10'h020, 0);
    #1;
    chk("ar_ready_pre", req_ready, 3'b010);
    tick();
    chk("ar_rspv_pre", rsp_valid, 3'b010);
    rst = 1'b1;
    #1;
    chk("ar_rspv_drop", rsp_valid, 0);
    chk("ar_ready_mask", req_ready, 0);
    chk("ar_we_mask", {bram_we_a, bram_we_b}, 0);
    set_req(0, 1, 0, 10'h010, 0);
    set_req(2, 1, 0, 10'h030, 0);
    tick();
    chk("ar_rspv_hold", rsp_valid, 0);
    chk("ar_ready_hold", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("ar_post_ready", req_ready, 3'b011);
    chk("ar_post_addr_a", bram_addr_a, 10'h010);
    tick();
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
